// File: rtl/fc_readout_argmax.sv
// Reads NUM_CLASSES fc scores per frame, accumulates them over STEPS frames,
// then reports the argmax class with a one-cycle result_valid pulse.
module fc_readout_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int STEPS       = 8,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [ADDR_W-1:0] src_start_address,
  output logic [ADDR_W-1:0] src_address,
  input  logic [DATA_W-1:0] src_readdata,
  output logic              src_write_en,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [3:0]        class_idx,
  output logic [ACC_W-1:0]  class_score,
  output logic [3:0]        step_count
);

  typedef enum logic [2:0] {StIdle, StRead, StAccTail, StArgmax, StFinish} state_t;

  localparam logic [3:0]       K_LAST    = 4'(NUM_CLASSES - 1);
  localparam logic [3:0]       STEP_LAST = 4'(STEPS);
  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  state_t r_state, w_state_next;

  logic [ADDR_W-1:0] r_src_address;
  logic [3:0]        r_k;
  logic [3:0]        r_scan;
  logic [3:0]        r_step_count;
  logic              r_busy, r_done, r_result_valid, r_final;
  logic [3:0]        r_class_idx;
  logic [ACC_W-1:0]  r_class_score;
  logic              r_p1_valid;
  logic [3:0]        r_p1_idx;
  logic [3:0]        r_best_idx;
  logic signed [ACC_W-1:0] r_best;
  logic signed [ACC_W-1:0] r_acc [NUM_CLASSES];

  logic [3:0]              w_step_inc;
  logic [ACC_W-1:0]        w_acc_cur;
  logic [ACC_W:0]          w_sum;
  logic [ACC_W-1:0]        w_sum_sat;
  logic signed [ACC_W-1:0] w_scan_val;

  assign w_step_inc = r_step_count + 4'd1;
  assign w_acc_cur  = r_acc[r_p1_idx];
  assign w_scan_val = r_acc[r_scan];

  // One guard bit above ACC_W exposes signed overflow of the add.
  always_comb begin
    w_sum     = {w_acc_cur[ACC_W-1], w_acc_cur}
              + {{(ACC_W+1-DATA_W){src_readdata[DATA_W-1]}}, src_readdata};
    w_sum_sat = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      w_sum_sat = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (start) w_state_next = StRead;
      StRead:    if (r_k == K_LAST) w_state_next = StAccTail;
      StAccTail: w_state_next = (w_step_inc == STEP_LAST) ? StArgmax : StFinish;
      StArgmax:  if (r_scan == K_LAST) w_state_next = StFinish;
      StFinish:  w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_address  <= '0;
      r_k            <= '0;
      r_scan         <= '0;
      r_step_count   <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
      r_final        <= 1'b0;
      r_class_idx    <= '0;
      r_class_score  <= '0;
      r_p1_valid     <= 1'b0;
      r_p1_idx       <= '0;
      r_best_idx     <= '0;
      r_best         <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) r_acc[i] <= '0;
    end else begin
      r_result_valid <= 1'b0;
      // RAM returns data one cycle after it registers the address.
      r_p1_valid <= (r_state == StRead);
      r_p1_idx   <= r_k;
      if (r_p1_valid) r_acc[r_p1_idx] <= w_sum_sat;

      case (r_state)
        StIdle: begin
          if (clear) begin
            r_step_count <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) r_acc[i] <= '0;
          end
          if (start) begin
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_src_address <= src_start_address;
            r_k           <= '0;
          end
        end
        StRead: begin
          if (r_k != K_LAST) begin
            r_src_address <= r_src_address + ADDR_W'(1);
            r_k           <= r_k + 4'd1;
          end
        end
        StAccTail: begin
          r_step_count <= w_step_inc;
          r_scan       <= '0;
          r_final      <= (w_step_inc == STEP_LAST);
        end
        StArgmax: begin
          if (r_scan == 4'd0) begin
            r_best     <= w_scan_val;
            r_best_idx <= '0;
          end else if (w_scan_val > r_best) begin
            r_best     <= w_scan_val;
            r_best_idx <= r_scan;
          end
          r_scan <= r_scan + 4'd1;
        end
        StFinish: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_final <= 1'b0;
          if (r_final) begin
            r_class_idx    <= r_best_idx;
            r_class_score  <= r_best;
            r_result_valid <= 1'b1;
            r_step_count   <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) r_acc[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign src_address  = r_src_address;
  assign src_write_en = 1'b0;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_result_valid;
  assign class_idx    = r_class_idx;
  assign class_score  = r_class_score;
  assign step_count   = r_step_count;

endmodule

// File: tb/tb_fc_readout_argmax.sv
// Directed bench for fc_readout_argmax: default DUT plus a 16-bit accumulator
// instance for saturation, each fed by its own registered-read RAM model.
module tb_fc_readout_argmax;

  logic        clk = 1'b0;
  logic        reset, start, clear;
  logic [13:0] start_addr;

  logic [13:0] addr_a, addr_s;
  logic [15:0] rd_a, rd_s;
  logic        we_a, we_s, busy_a, busy_s, done_a, done_s, rv_a, rv_s;
  logic [3:0]  idx_a, idx_s, step_a, step_s;
  logic [23:0] score_a;
  logic [15:0] score_s;

  logic [15:0] mem_a [16];
  logic [15:0] mem_s [16];
  logic [13:0] addr_log [64];
  bit          we_bad;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_a <= mem_a[addr_a[3:0]];
    rd_s <= mem_s[addr_s[3:0]];
  end

  fc_readout_argmax dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .src_start_address(start_addr), .src_address(addr_a), .src_readdata(rd_a),
    .src_write_en(we_a), .busy(busy_a), .done(done_a), .result_valid(rv_a),
    .class_idx(idx_a), .class_score(score_a), .step_count(step_a)
  );

  fc_readout_argmax #(.ACC_W(16)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .src_start_address(start_addr), .src_address(addr_s), .src_readdata(rd_s),
    .src_write_en(we_s), .busy(busy_s), .done(done_s), .result_valid(rv_s),
    .class_idx(idx_s), .class_score(score_s), .step_count(step_s)
  );

  task automatic fill_a(input logic [15:0] base, input int sp, input logic [15:0] spv);
    for (int i = 0; i < 16; i++) mem_a[i] = (i == sp) ? spv : base;
  endtask

  // Runs one frame; start/clear extra pulses land on edge E<start_at>/E<clear_at>.
  task automatic do_frame(input int start_at, input int clear_at, input bit clr0,
                          output int lat, output int rv_cnt, output int rv_at);
    int cyc;
    lat = -1; rv_cnt = 0; rv_at = -1; we_bad = 0;
    @(negedge clk); start = 1'b1; clear = clr0;
    @(posedge clk); #1;
    cyc = 0; addr_log[0] = addr_a; start = 1'b0; clear = 1'b0;
    while (lat < 0 && cyc < 60) begin
      start = (start_at == cyc + 1);
      clear = (clear_at == cyc + 1);
      @(posedge clk); #1;
      cyc++;
      addr_log[cyc] = addr_a;
      if (we_a !== 1'b0 || we_s !== 1'b0) we_bad = 1;
      if (rv_a === 1'b1) begin rv_cnt++; rv_at = cyc; end
      if (done_a === 1'b1) lat = cyc;
    end
    start = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
    if (rv_a === 1'b1) rv_cnt++;
  endtask

  // Eight frames; early_err counts non-final frames with wrong latency or a result pulse.
  task automatic run_inference(output int lat, output int rv_cnt, output int rv_at,
                               output int early_err);
    early_err = 0;
    for (int f = 0; f < 7; f++) begin
      do_frame(-1, -1, 1'b0, lat, rv_cnt, rv_at);
      if (lat != 12 || rv_cnt != 0) early_err++;
    end
    do_frame(-1, -1, 1'b0, lat, rv_cnt, rv_at);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; clear = 1'b0; start_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
    total++; if (rv_a !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", rv_a); end
    total++; if (idx_a !== 4'd0 || score_a !== 24'd0) begin
      bad++; $display("FAIL reset_class got=%0d/%0d exp=0/0", idx_a, score_a);
    end
    total++; if (step_a !== 4'd0) begin bad++; $display("FAIL reset_step got=%0d exp=0", step_a); end
    total++; if (addr_a !== 14'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr_a); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_single_frame();
    int lat, rvc, rva, addr_err;
    for (int i = 0; i < 16; i++) mem_a[i] = 16'(i + 1);
    do_frame(-1, -1, 1'b0, lat, rvc, rva);
    addr_err = 0;
    for (int k = 0; k < 10; k++) if (addr_log[k] !== 14'(k)) addr_err++;
    total++; if (lat != 12) begin bad++; $display("FAIL frame_latency got=%0d exp=12", lat); end
    total++; if (step_a !== 4'd1) begin bad++; $display("FAIL frame_step got=%0d exp=1", step_a); end
    total++; if (rvc != 0) begin bad++; $display("FAIL frame_rv got=%0d exp=0", rvc); end
    total++; if (addr_err != 0) begin bad++; $display("FAIL frame_addr_sweep got=%0d_bad exp=0", addr_err); end
    total++; if (we_bad) begin bad++; $display("FAIL frame_write_en got=1 exp=0"); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL frame_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_inference();
    int lat, rvc, rva, early;
    pulse_clear();
    fill_a(16'd5, 3, 16'd100);
    run_inference(lat, rvc, rva, early);
    total++; if (early != 0) begin bad++; $display("FAIL inf_early got=%0d exp=0", early); end
    total++; if (lat != 22 || rva != 22) begin
      bad++; $display("FAIL inf_latency got=%0d/%0d exp=22/22", lat, rva);
    end
    total++; if (rvc != 1) begin bad++; $display("FAIL inf_rv_pulse got=%0d exp=1", rvc); end
    total++; if (idx_a !== 4'd3) begin bad++; $display("FAIL inf_idx got=%0d exp=3", idx_a); end
    total++; if (score_a !== 24'd800) begin bad++; $display("FAIL inf_score got=%0d exp=800", score_a); end
    total++; if (step_a !== 4'd0) begin bad++; $display("FAIL inf_step got=%0d exp=0", step_a); end
  endtask

  task automatic test_ties();
    int lat, rvc, rva, early;
    fill_a(16'd7, -1, 16'd0);
    run_inference(lat, rvc, rva, early);
    total++; if (idx_a !== 4'd0 || score_a !== 24'd56 || rvc != 1) begin
      bad++; $display("FAIL ties got=%0d/%0d/%0d exp=0/56/1", idx_a, score_a, rvc);
    end
  endtask

  task automatic test_negative();
    int lat, rvc, rva, early;
    fill_a(16'hFFCE, 9, 16'hFFFF);
    run_inference(lat, rvc, rva, early);
    total++; if (idx_a !== 4'd9 || score_a !== 24'hFFFFF8) begin
      bad++; $display("FAIL negative got=%0d/%h exp=9/fffff8", idx_a, score_a);
    end
  endtask

  task automatic test_saturation();
    int lat, rvc, rva, early;
    for (int i = 0; i < 16; i++) mem_s[i] = (i == 2) ? 16'h7FFF : 16'h0000;
    run_inference(lat, rvc, rva, early);
    total++; if (score_s !== 16'h7FFF) begin
      bad++; $display("FAIL sat_score got=%h exp=7fff", score_s);
    end
    total++; if (idx_s !== 4'd2) begin bad++; $display("FAIL sat_idx got=%0d exp=2", idx_s); end
    for (int i = 0; i < 16; i++) mem_s[i] = 16'h0000;
  endtask

  task automatic test_ignore();
    int lat, rvc, rva;
    pulse_clear();
    fill_a(16'd1, -1, 16'd0);
    do_frame(5, 7, 1'b0, lat, rvc, rva);
    total++; if (lat != 12) begin bad++; $display("FAIL busy_start_latency got=%0d exp=12", lat); end
    total++; if (step_a !== 4'd1) begin bad++; $display("FAIL busy_clear_step got=%0d exp=1", step_a); end
    do_frame(-1, -1, 1'b0, lat, rvc, rva);
    do_frame(-1, -1, 1'b0, lat, rvc, rva);
    total++; if (step_a !== 4'd3) begin bad++; $display("FAIL three_frames_step got=%0d exp=3", step_a); end
    do_frame(-1, -1, 1'b1, lat, rvc, rva);
    total++; if (step_a !== 4'd1 || lat != 12) begin
      bad++; $display("FAIL clear_start got=%0d/%0d exp=1/12", step_a, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, rvc, rva, early, rv_seen;
    pulse_clear();
    fill_a(16'd4, 6, 16'd9);
    for (int f = 0; f < 7; f++) do_frame(-1, -1, 1'b0, lat, rvc, rva);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    total++; if (busy_a !== 1'b0 || step_a !== 4'd0) begin
      bad++; $display("FAIL midreset got=busy%b/step%0d exp=0/0", busy_a, step_a);
    end
    reset = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (rv_a === 1'b1) rv_seen++;
    end
    total++; if (rv_seen != 0) begin bad++; $display("FAIL midreset_rv got=%0d exp=0", rv_seen); end
    fill_a(16'd5, 3, 16'd100);
    run_inference(lat, rvc, rva, early);
    total++; if (idx_a !== 4'd3 || score_a !== 24'd800 || rvc != 1 || early != 0) begin
      bad++; $display("FAIL after_reset got=%0d/%0d/%0d/%0d exp=3/800/1/0", idx_a, score_a, rvc, early);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_s[i] = '0; end
    test_reset();
    test_single_frame();
    test_inference();
    test_ties();
    test_negative();
    test_saturation();
    test_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
